booth_mul_arbiter: RTL and testbench
====================================

Name: booth_mul_arbiter

Overview:
- Shares one Booth multiplier unit (the controller+datapath pair with start/finished handshake and two-cycle result upload) among N requesters.
- Round-robin arbitration; drives the multiplier's start pulse and operands; reassembles the 2W-bit product from the two upload cycles.
- Returns the product, tagged with the requester ID, as a one-cycle response.
- Sits between client blocks and the multiplier.

Parameters:
N, 4, number of requesters (2..8)
W, 8, operand width; product is 2W bits
IDW, 2, requester ID width, equal to clog2(N)
TIMEOUT, 64, max cycles from mul_start to mul_finished before job is aborted

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-low reset
req  in  N  per-requester job request, held until gnt
req_x  in  N*W  packed multiplicands, slice i belongs to requester i
req_y  in  N*W  packed multipliers
gnt  out  N  one-hot, one-cycle pulse: operands of granted requester captured
rsp_valid  out  1  one-cycle response strobe
rsp_id  out  IDW  requester the response belongs to
rsp_prod  out  2W  signed product {A,X}
rsp_err  out  1  qualifies rsp_valid: timeout or incomplete upload
mul_start  out  1  one-cycle start pulse to multiplier
mul_x  out  W  multiplicand to multiplier
mul_y  out  W  multiplier operand to multiplier
mul_data  in  W  multiplier upload bus
mul_sel  in  2  upload selector: 01 = X half (low), 10 = A half (high), else idle
mul_finished  in  1  multiplier done pulse

Behaviour:
- Reset (rst=0 at rising edge):
  - State goes to IDLE.
  - gnt, rsp_valid, rsp_err, mul_start are 0.
  - rsp_id, rsp_prod, mul_x, mul_y are 0.
  - RR pointer is 0; timeout counter and half-captured flags are cleared.
- Reset mid-job: the job is dropped and no response is issued. A requester whose req stays high is re-arbitrated after reset.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req is set, pick the first set bit at or after the RR pointer (wrapping modulo N).
  - Latch its ID and operands into mul_x/mul_y, then go to ISSUE.
- ISSUE (exactly 1 cycle):
  - gnt[id]=1 and mul_start=1.
  - Timeout counter is cleared; RR pointer becomes (id+1) mod N.
  - Go to WAIT.
- WAIT:
  - mul_x/mul_y are held stable, because the multiplier loads operands several cycles after start.
  - mul_sel=01: capture mul_data into low half, set lo_ok.
  - mul_sel=10: capture into high half, set hi_ok.
  - mul_sel=00 or 11: nothing is captured.
  - A repeated half overwrites the previous capture.
  - mul_finished=1: go to RESP with err = ~(lo_ok & hi_ok).
  - If the counter reaches TIMEOUT-1 without finished: go to RESP with err=1. Later stray finished/sel inputs are ignored while in IDLE.
- RESP (1 cycle):
  - rsp_valid=1, rsp_id = latched ID.
  - rsp_prod = {hi,lo}, or 0 if err; rsp_err = err.
  - Go to IDLE.
- Latency:
  - req high in IDLE at edge t gives gnt/mul_start in cycle t+1.
  - rsp_valid comes the cycle after mul_finished is sampled.
- No response backpressure; requesters must accept rsp_valid when it arrives.
- Only one job is in flight. Requests arriving while busy wait; the RR pointer guarantees each waiting requester is served within N jobs.
- A req dropped before gnt is a withdrawal and is legal; no grant is given.
- The same requester may request again immediately after its gnt. The RR pointer gives priority to others first.
- mul_finished coincident with mul_sel != 00: the half is captured in the same cycle, and err is evaluated including that capture.

Decomposition:
- Package booth_arb_pkg holds:
  - state enum (IDLE, ISSUE, WAIT, RESP)
  - upload selector constants SEL_X=2'b01, SEL_A=2'b10
  - default W/N/TIMEOUT constants
- One natural sub-module: rr_picker. It is combinational: req vector plus pointer in, one-hot and index out, parameterised on N.

Test Plan:
- N=4, W=8, req=0001, x=5, y=-3 (8'hFD); multiplier model uploads lo=8'hF1 then hi=8'hFF, then finished:
  - gnt=0001 and mul_start at t+1
  - rsp_id=0, rsp_prod=16'hFFF1, rsp_err=0
- req=1111 held constantly, 8 jobs:
  - grant order 0,1,2,3,0,1,2,3
  - each rsp_id matches the preceding gnt
- Model never asserts finished, TIMEOUT=64:
  - rsp_valid at 64 cycles after mul_start, with rsp_err=1 and rsp_prod=0
  - next request then served normally
- Model skips the A upload and asserts finished after X only:
  - rsp_err=1, rsp_prod=0
- Reset (rst=0) during WAIT with req=0100 still high:
  - no rsp_valid; all outputs 0
  - after release, gnt=0100 re-issued within 2 cycles
- Operands x=-128, y=-128:
  - rsp_prod=16'h4000
  - mul_x/mul_y stable from ISSUE until finished

Source files
------------

// File: rtl/booth_arb_pkg.sv
// Shared types and constants for the Booth multiplier arbiter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: FSM state enum, multiplier upload selector codes, default sizes.
package booth_arb_pkg;

  localparam int DEF_N       = 4;
  localparam int DEF_W       = 8;
  localparam int DEF_TIMEOUT = 64;

  // Upload selector codes driven by the multiplier on mul_sel.
  localparam logic [1:0] SEL_X = 2'b01;  // low half of the product
  localparam logic [1:0] SEL_A = 2'b10;  // high half of the product

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/booth_mul_arbiter_rr_picker.sv
// Round-robin picker: first set request bit at or after ptr_i, wrapping mod N.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to consume the pick.
// Ports: req_i (N request bits), ptr_i (start index), gnt_o (one-hot pick),
//        idx_o (binary pick), any_o (at least one request set).
module rr_picker #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req_i,
  input  logic [IDW-1:0] ptr_i,
  output logic [N-1:0]   gnt_o,
  output logic [IDW-1:0] idx_o,
  output logic           any_o
);

  localparam int IW = IDW + 1;
  localparam logic [IW-1:0] N_W = IW'(N);

  // One extra bit so ptr + offset never overflows before the modulo wrap.
  logic [IW-1:0] pos;
  logic          found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    pos   = '0;
    for (int k = 0; k < N; k++) begin
      pos = {1'b0, ptr_i} + k[IW-1:0];
      if (pos >= N_W) begin
        pos = pos - N_W;
      end
      if (!found && req_i[pos[IDW-1:0]]) begin
        found                = 1'b1;
        gnt_o[pos[IDW-1:0]]  = 1'b1;
        idx_o                = pos[IDW-1:0];
      end
    end
  end

  assign any_o = found;

endmodule

// File: rtl/booth_mul_arbiter.sv
// Shares one start/finished Booth multiplier among N requesters, round-robin.
// Latency: gnt/mul_start one cycle after req seen in IDLE; response one cycle after mul_finished.
// Backpressure: requests wait while a job is in flight; responses cannot be stalled.
// Ports: clk/rst (sync, active-low); req/req_x/req_y from clients, gnt back;
//        rsp_valid/rsp_id/rsp_prod/rsp_err response strobe; mul_start/mul_x/mul_y
//        to the multiplier; mul_data/mul_sel/mul_finished from its upload side.
module booth_mul_arbiter
  import booth_arb_pkg::*;
#(
  parameter int N       = DEF_N,
  parameter int W       = DEF_W,
  parameter int IDW     = $clog2(N),
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] req_x,
  input  logic [N*W-1:0] req_y,
  output logic [N-1:0]   gnt,
  output logic           rsp_valid,
  output logic [IDW-1:0] rsp_id,
  output logic [2*W-1:0] rsp_prod,
  output logic           rsp_err,
  output logic           mul_start,
  output logic [W-1:0]   mul_x,
  output logic [W-1:0]   mul_y,
  input  logic [W-1:0]   mul_data,
  input  logic [1:0]     mul_sel,
  input  logic           mul_finished
);

  localparam int CW = $clog2(TIMEOUT) + 1;

  state_t           state_q;
  logic [N-1:0]     gnt_q;
  logic             mul_start_q;
  logic             rsp_valid_q;
  logic             rsp_err_q;
  logic [IDW-1:0]   rsp_id_q;
  logic [2*W-1:0]   rsp_prod_q;
  logic [W-1:0]     mul_x_q;
  logic [W-1:0]     mul_y_q;
  logic [IDW-1:0]   id_q;
  logic [IDW-1:0]   rr_ptr_q;
  logic [CW-1:0]    cnt_q;
  logic [W-1:0]     lo_q, hi_q;
  logic             lo_ok_q, hi_ok_q;

  logic [W-1:0]     lo_d, hi_d;
  logic             lo_ok_d, hi_ok_d;
  logic             fin_err;
  logic [IDW-1:0]   rr_ptr_d;

  logic [N-1:0]     pick_oh;
  logic [IDW-1:0]   pick_idx;
  logic             pick_any;

  logic [W-1:0]     x_arr [N];
  logic [W-1:0]     y_arr [N];

  for (genvar gi = 0; gi < N; gi++) begin : g_slice
    assign x_arr[gi] = req_x[gi*W +: W];
    assign y_arr[gi] = req_y[gi*W +: W];
  end

  rr_picker #(
    .N   (N),
    .IDW (IDW)
  ) u_pick (
    .req_i (req),
    .ptr_i (rr_ptr_q),
    .gnt_o (pick_oh),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  // Upload capture including the current cycle, so a half that arrives
  // together with mul_finished still counts toward the error decision.
  always_comb begin
    lo_d    = lo_q;
    hi_d    = hi_q;
    lo_ok_d = lo_ok_q;
    hi_ok_d = hi_ok_q;
    if (mul_sel == SEL_X) begin
      lo_d    = mul_data;
      lo_ok_d = 1'b1;
    end else if (mul_sel == SEL_A) begin
      hi_d    = mul_data;
      hi_ok_d = 1'b1;
    end
  end

  assign fin_err  = ~(lo_ok_d & hi_ok_d);
  assign rr_ptr_d = (id_q == IDW'(N - 1)) ? '0 : id_q + IDW'(1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      mul_start_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_id_q    <= '0;
      rsp_prod_q  <= '0;
      mul_x_q     <= '0;
      mul_y_q     <= '0;
      id_q        <= '0;
      rr_ptr_q    <= '0;
      cnt_q       <= '0;
      lo_q        <= '0;
      hi_q        <= '0;
      lo_ok_q     <= 1'b0;
      hi_ok_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_any) begin
            id_q        <= pick_idx;
            mul_x_q     <= x_arr[pick_idx];
            mul_y_q     <= y_arr[pick_idx];
            gnt_q       <= pick_oh;
            mul_start_q <= 1'b1;
            // Counter starts at the start pulse so the abort lands exactly
            // TIMEOUT cycles after mul_start.
            cnt_q       <= '0;
            lo_ok_q     <= 1'b0;
            hi_ok_q     <= 1'b0;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          gnt_q       <= '0;
          mul_start_q <= 1'b0;
          cnt_q       <= cnt_q + CW'(1);
          rr_ptr_q    <= rr_ptr_d;
          state_q     <= WAIT;
        end
        WAIT: begin
          // mul_x/mul_y are deliberately untouched here: the multiplier
          // samples its operands some cycles after the start pulse.
          lo_q    <= lo_d;
          hi_q    <= hi_d;
          lo_ok_q <= lo_ok_d;
          hi_ok_q <= hi_ok_d;
          if (mul_finished) begin
            rsp_valid_q <= 1'b1;
            rsp_id_q    <= id_q;
            rsp_err_q   <= fin_err;
            rsp_prod_q  <= fin_err ? '0 : {hi_d, lo_d};
            state_q     <= RESP;
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            rsp_valid_q <= 1'b1;
            rsp_id_q    <= id_q;
            rsp_err_q   <= 1'b1;
            rsp_prod_q  <= '0;
            state_q     <= RESP;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        RESP: begin
          rsp_valid_q <= 1'b0;
          rsp_err_q   <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign mul_start = mul_start_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_prod  = rsp_prod_q;
  assign mul_x     = mul_x_q;
  assign mul_y     = mul_y_q;

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Self-checking bench for booth_mul_arbiter (N=4, W=8, TIMEOUT=64).
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_booth_mul_arbiter;
  import booth_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_x, req_y;
  logic [3:0]  gnt;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_prod;
  logic        rsp_err;
  logic        mul_start;
  logic [7:0]  mul_x, mul_y;
  logic [7:0]  mul_data;
  logic [1:0]  mul_sel;
  logic        mul_finished;

  int checks = 0;
  int errors = 0;
  logic       stab_ok;
  logic [7:0] ref_x, ref_y;

  booth_mul_arbiter #(.N(4), .W(8), .IDW(2), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .req(req), .req_x(req_x), .req_y(req_y),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_prod(rsp_prod),
    .rsp_err(rsp_err), .mul_start(mul_start), .mul_x(mul_x), .mul_y(mul_y),
    .mul_data(mul_data), .mul_sel(mul_sel), .mul_finished(mul_finished)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end

  typedef struct {
    logic [3:0]  req;
    logic [7:0]  x;
    logic [7:0]  y;
    int          mode;     // 0 normal, 1 skip A, 2 A with finished, 3 repeated X
    logic [1:0]  exp_id;
    logic [15:0] exp_prod;
    logic        exp_err;
  } vec_t;

  vec_t vt[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Winner slice gets the real operands, every other slice their complement.
  task automatic set_ops(input logic [7:0] x, input logic [7:0] y, input int w);
    for (int i = 0; i < 4; i++) begin
      req_x[i*8 +: 8] = (i == w) ? x : ~x;
      req_y[i*8 +: 8] = (i == w) ? y : ~y;
    end
  endtask

  task automatic drv(input logic [1:0] s, input logic [7:0] d, input logic f);
    mul_sel      = s;
    mul_data     = d;
    mul_finished = f;
    tick();
    if (mul_x !== ref_x || mul_y !== ref_y) stab_ok = 1'b0;
    if (!f && rsp_valid !== 1'b0) stab_ok = 1'b0;
  endtask

  // Multiplier model: called in the ISSUE cycle, returns in the RESP cycle.
  task automatic upload(input int mode, input logic [7:0] x, input logic [7:0] y);
    logic [15:0] p;
    p = $signed(x) * $signed(y);
    stab_ok = 1'b1;
    ref_x = x;
    ref_y = y;
    repeat (3) drv(2'b00, 8'h00, 1'b0);
    case (mode)
      1: begin
        drv(SEL_X, p[7:0], 1'b0);
        drv(2'b00, 8'h00, 1'b1);
      end
      2: begin
        drv(SEL_X, p[7:0], 1'b0);
        drv(SEL_A, p[15:8], 1'b1);
      end
      3: begin
        drv(SEL_X, 8'hAA, 1'b0);
        drv(SEL_A, p[15:8], 1'b0);
        drv(SEL_X, p[7:0], 1'b0);
        drv(2'b11, 8'h55, 1'b1);
      end
      default: begin
        drv(SEL_X, p[7:0], 1'b0);
        drv(SEL_A, p[15:8], 1'b0);
        drv(2'b00, 8'h00, 1'b1);
      end
    endcase
    mul_sel      = 2'b00;
    mul_data     = 8'h00;
    mul_finished = 1'b0;
  endtask

  task automatic run_row(input vec_t v);
    int n;
    set_ops(v.x, v.y, int'(v.exp_id));
    req = v.req;
    n = 0;
    do begin
      tick();
      n++;
    end while (gnt === 4'b0000 && n < 4);
    chk("gnt_latency", n, 1);
    chk("gnt", gnt, 4'b0001 << v.exp_id);
    chk("mul_start", mul_start, 1);
    chk("mul_x", mul_x, v.x);
    chk("mul_y", mul_y, v.y);
    req = 4'b0000;
    upload(v.mode, v.x, v.y);
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_id", rsp_id, v.exp_id);
    chk("rsp_prod", rsp_prod, v.exp_prod);
    chk("rsp_err", rsp_err, v.exp_err);
    chk("operand_stable", stab_ok, 1);
    tick();
    chk("rsp_one_cycle", rsp_valid, 0);
  endtask

  initial begin
    int n;
    logic seen;
    logic [15:0] rr_exp[4];
    vec_t v;

    vt[0] = '{4'b0001, 8'h05, 8'hFD, 0, 2'd0, 16'hFFF1, 1'b0};
    vt[1] = '{4'b0100, 8'h80, 8'h80, 0, 2'd2, 16'h4000, 1'b0};
    vt[2] = '{4'b0010, 8'h07, 8'h09, 1, 2'd1, 16'h0000, 1'b1};
    vt[3] = '{4'b1000, 8'hFF, 8'hFF, 2, 2'd3, 16'h0001, 1'b0};
    vt[4] = '{4'b0001, 8'h7F, 8'h80, 3, 2'd0, 16'hC080, 1'b0};
    vt[5] = '{4'b1001, 8'h03, 8'h04, 0, 2'd3, 16'h000C, 1'b0};
    vt[6] = '{4'b0011, 8'h02, 8'h81, 0, 2'd0, 16'hFF02, 1'b0};
    vt[7] = '{4'b0011, 8'h10, 8'h10, 0, 2'd1, 16'h0100, 1'b0};
    rr_exp = '{16'hFFFE, 16'hFFFC, 16'hFFFA, 16'hFFF8};

    rst = 1'b0; req = 4'b0; req_x = '0; req_y = '0;
    mul_data = 8'h00; mul_sel = 2'b00; mul_finished = 1'b0;
    tick(); tick();
    chk("reset_outputs", {gnt, rsp_valid, rsp_err, mul_start, rsp_id, rsp_prod, mul_x, mul_y}, 0);
    rst = 1'b1;

    for (int i = 0; i < 8; i++) run_row(vt[i]);

    // Fresh pointer, then all four requesting continuously.
    rst = 1'b0; tick(); tick(); rst = 1'b1; tick();
    for (int i = 0; i < 4; i++) begin
      req_x[i*8 +: 8] = 8'(i + 1);
      req_y[i*8 +: 8] = 8'hFE;
    end
    req = 4'b1111;
    for (int j = 0; j < 8; j++) begin
      n = 0;
      do begin
        tick();
        n++;
      end while (gnt === 4'b0000 && n < 10);
      chk("rr_gnt", gnt, 4'b0001 << (j % 4));
      upload(0, 8'((j % 4) + 1), 8'hFE);
      chk("rr_rsp_id", rsp_id, j % 4);
      chk("rr_rsp_prod", rsp_prod, rr_exp[j % 4]);
      tick();
    end
    req = 4'b0000;

    // Multiplier never finishes: abort 64 cycles after mul_start.
    set_ops(8'h01, 8'h01, 0);
    req = 4'b0001;
    n = 0;
    do begin
      tick();
      n++;
    end while (gnt === 4'b0000 && n < 4);
    chk("to_gnt", gnt, 4'b0001);
    req = 4'b0000;
    n = 0;
    do begin
      tick();
      n++;
    end while (rsp_valid !== 1'b1 && n < 100);
    chk("timeout_latency", n, 64);
    chk("timeout_err", rsp_err, 1);
    chk("timeout_prod", rsp_prod, 0);
    chk("timeout_id", rsp_id, 0);
    tick();
    // Stray upload/finished while idle must be ignored.
    mul_finished = 1'b1; mul_sel = SEL_X; mul_data = 8'h77;
    tick();
    mul_finished = 1'b0; mul_sel = 2'b00; mul_data = 8'h00;
    tick();
    chk("stray_ignored", {rsp_valid, gnt, mul_start}, 0);
    v = '{4'b0010, 8'h03, 8'h05, 0, 2'd1, 16'h000F, 1'b0};
    run_row(v);

    // Reset in WAIT with the request still held.
    set_ops(8'h0C, 8'h0D, 2);
    req = 4'b0100;
    n = 0;
    do begin
      tick();
      n++;
    end while (gnt === 4'b0000 && n < 4);
    chk("mid_gnt", gnt, 4'b0100);
    tick(); tick(); tick();
    mul_sel = SEL_X; mul_data = 8'h9C;
    tick();
    mul_sel = 2'b00; mul_finished = 1'b1;
    rst = 1'b0;
    tick(); tick();
    chk("mid_reset_outputs", {gnt, rsp_valid, rsp_err, mul_start, rsp_id, rsp_prod, mul_x, mul_y}, 0);
    mul_finished = 1'b0;
    rst = 1'b1;
    n = 0;
    seen = 1'b0;
    do begin
      tick();
      n++;
      if (rsp_valid === 1'b1) seen = 1'b1;
    end while (gnt === 4'b0000 && n < 5);
    chk("rearb_within_2", (n <= 2), 1);
    chk("rearb_gnt", gnt, 4'b0100);
    chk("no_rsp_after_reset", seen, 0);
    req = 4'b0000;
    upload(0, 8'h0C, 8'h0D);
    chk("rearb_rsp_id", rsp_id, 2);
    chk("rearb_rsp_prod", rsp_prod, 16'h009C);
    chk("rearb_rsp_err", rsp_err, 0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
